// File: rtl/irq_timer_pkg.sv
// -----------------------------------------------------------------------------
// irq_timer_pkg
// Shared definitions for the programmable interrupt timer bank:
//   - per-channel FSM state encoding
//   - register offsets inside a channel's 16-byte window (word index addr[3:2])
//   - CTRL mode codes and CTRL bit positions
// -----------------------------------------------------------------------------
package irq_timer_pkg;

  // Per-channel countdown FSM
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    FIRE = 2'd3
  } ch_state_e;

  // Register word offsets within a channel window
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // CTRL.mode codes; the reserved codes 2'b1x behave as one-shot
  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_W        = 4;

endpackage : irq_timer_pkg

// File: rtl/irq_timer_channel.sv
// -----------------------------------------------------------------------------
// irq_timer_channel
// One countdown timer channel: CTRL/PRESET/COUNT/pending registers and the
// IDLE -> LOAD -> CNT -> FIRE state machine.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   ctrl_we_i    write strobe for CTRL  (wdata_i[3:0])
//   preset_we_i  write strobe for PRESET (wdata_i[CNT_W-1:0])
//   status_we_i  write strobe for STATUS (wdata_i[0]=1 clears pending)
//   wdata_i      bus write data
//   ctrl_o       {im, mode[1:0], en}
//   preset_o     current PRESET value
//   count_o      current COUNT value
//   pending_o    sticky pending flag
// -----------------------------------------------------------------------------
module irq_timer_channel
  import irq_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ctrl_we_i,
  input  logic              preset_we_i,
  input  logic              status_we_i,
  input  logic [31:0]       wdata_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  preset_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              pending_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic             im_q, im_d;
  logic             pending_q, pending_d;
  logic             fire_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      count_q   <= '0;
      preset_q  <= '0;
      en_q      <= 1'b0;
      mode_q    <= MODE_ONESHOT;
      im_q      <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      preset_q  <= preset_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      im_q      <= im_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    preset_d  = preset_q;
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    pending_d = pending_q;
    fire_set  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en_q) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;                       // pause: COUNT frozen
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          // COUNT of 0 or 1 both expire here, so PRESET=0 acts like PRESET=1
          count_d = '0;
          state_d = FIRE;
        end
      end
      FIRE: begin
        fire_set = 1'b1;
        if (en_q && (mode_q == MODE_PERIODIC)) begin
          state_d = LOAD;
        end else begin
          en_d    = 1'b0;                       // one-shot self-disable
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A bus write to CTRL overrides the one-shot self-clear of en.
    if (ctrl_we_i) begin
      en_d   = wdata_i[CTRL_EN_BIT];
      mode_d = wdata_i[CTRL_MODE_LSB +: 2];
      im_d   = wdata_i[CTRL_IM_BIT];
    end

    // PRESET only reaches COUNT through LOAD, so writes mid-count are deferred.
    if (preset_we_i) preset_d = wdata_i[CNT_W-1:0];

    // Set has priority over a same-edge write-one-to-clear.
    if (status_we_i && wdata_i[0]) pending_d = 1'b0;
    if (fire_set) pending_d = 1'b1;
  end

  assign ctrl_o    = {im_q, mode_q, en_q};
  assign preset_o  = preset_q;
  assign count_o   = count_q;
  assign pending_o = pending_q;

endmodule : irq_timer_channel

// File: rtl/irq_timer_bank.sv
// -----------------------------------------------------------------------------
// irq_timer_bank
// Bank of NUM_CH memory-mapped countdown timers driving one interrupt line.
// Each channel occupies a 16-byte window: CTRL, PRESET, COUNT, STATUS.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   addr     byte address (channel = addr >> 4, offset = addr[3:2])
//   we       write strobe
//   wdata    write data
//   rdata    combinational read data for addr (0 for unmapped channels)
//   irq      OR of all pending & im
//   irq_vec  per-channel pending & im
//   irq_id   lowest set irq_vec index, 0 when none
// -----------------------------------------------------------------------------
module irq_timer_bank
  import irq_timer_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int AW     = 3 + $clog2(NUM_CH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [2:0]        irq_id
);

  // Channel index kept at full AW width so a NUM_CH=1 bank still has a
  // well-formed field; indices >= NUM_CH simply never match below.
  logic [AW-1:0] ch_idx;
  logic [1:0]    offset;

  assign ch_idx = addr >> 4;
  assign offset = addr[3:2];

  logic [CTRL_W-1:0] ctrl_w   [NUM_CH];
  logic [CNT_W-1:0]  preset_w [NUM_CH];
  logic [CNT_W-1:0]  count_w  [NUM_CH];
  logic [NUM_CH-1:0] pending_w;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr_sel;
    assign wr_sel = we && (ch_idx == AW'(gi));

    // COUNT has no write strobe: writes to it are dropped here.
    irq_timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_i       (clk),
      .rst_ni      (reset),
      .ctrl_we_i   (wr_sel && (offset == OFF_CTRL)),
      .preset_we_i (wr_sel && (offset == OFF_PRESET)),
      .status_we_i (wr_sel && (offset == OFF_STATUS)),
      .wdata_i     (wdata),
      .ctrl_o      (ctrl_w[gi]),
      .preset_o    (preset_w[gi]),
      .count_o     (count_w[gi]),
      .pending_o   (pending_w[gi])
    );

    assign irq_vec[gi] = pending_w[gi] & ctrl_w[gi][CTRL_IM_BIT];
  end

  assign irq = |irq_vec;

  // Descending scan so the lowest active index is the last assignment.
  always_comb begin
    irq_id = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (irq_vec[i]) irq_id = 3'(i);
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == AW'(i)) begin
        case (offset)
          OFF_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_w[i]};
          OFF_PRESET: rdata = 32'(preset_w[i]);
          OFF_COUNT:  rdata = 32'(count_w[i]);
          OFF_STATUS: rdata = {31'd0, pending_w[i]};
          default:    rdata = '0;
        endcase
      end
    end
  end

endmodule : irq_timer_bank

// File: doc/irq_timer_bank.md
Name: irq_timer_bank

Overview:
- Parametrised bank of NUM_CH programmable countdown timers on the CPU's memory-mapped device bus.
- Drives the CPU's interrupt input, replacing the fixed, bench-driven interrupt stimulus with programmable, repeatable interrupt sources.
- Each channel runs in one-shot or periodic mode and raises a sticky pending flag that software clears.
- Pending, unmasked flags are OR-reduced onto a single irq line; a lowest-channel-first ID is also provided.

Parameters:
- NUM_CH, 2, number of timer channels (1..8)
- CNT_W, 32, counter and preset width (8..32)
- AW, 3+clog2(NUM_CH)+1, byte address width; each channel occupies a 16-byte window

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- addr  in  AW  byte address, word aligned; addr[1:0] ignored
- we  in  1  write strobe, sampled on rising clk
- wdata  in  32  write data
- rdata  out  32  combinational read data for addr
- irq  out  1  OR of all (pending & im) across channels
- irq_vec  out  NUM_CH  per-channel pending & im
- irq_id  out  3  index of the lowest set irq_vec bit; 0 when none set

Behaviour:
- Address decoding:
  - channel = addr[AW-1:4]; offset = addr[3:2].
  - Offset 0 CTRL (rw): [0] en, [2:1] mode (00 one-shot, 01 periodic, 1x reserved and treated as one-shot), [3] im.
  - Offset 1 PRESET (rw, low CNT_W bits).
  - Offset 2 COUNT (ro).
  - Offset 3 STATUS (bit0 pending; writing 1 clears it, writing 0 has no effect).
- Unmapped channel index (>= NUM_CH): reads return 0; writes are ignored. Writes to COUNT are ignored. Unused rdata bits read 0.
- Reset (reset=0, asynchronous):
  - All CTRL, PRESET, COUNT and pending clear to 0; all channel FSMs go to IDLE.
  - irq=0, irq_vec=0, irq_id=0 immediately, without waiting for a clock edge.
  - Reset mid-count discards all progress.
- Per-channel FSM, states IDLE, LOAD, CNT, FIRE:
  - IDLE: if en -> LOAD; COUNT holds.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT: if !en -> IDLE with COUNT frozen. Else if COUNT > 1, COUNT <= COUNT-1. Else COUNT <= 0 and -> FIRE.
  - FIRE: pending <= 1. If periodic and en -> LOAD. Else clear en (one-shot self-disable) and -> IDLE.
- Latency: a CTRL write with en=1 on edge T with PRESET=P (P>=1) gives:
  - LOAD at T+1; COUNT=P after edge T+2; COUNT=0 and state FIRE after edge T+2+P; pending=1 and irq high after edge T+3+P.
  - PRESET=0 behaves exactly as PRESET=1.
- Periodic spacing: successive pending sets are P+2 cycles apart.
- Write timing: PRESET writes while counting take effect only at the next LOAD. Clearing en while in FIRE still sets pending that cycle, and the FSM then goes to IDLE.
- Simultaneous events:
  - FIRE-set and a W1C of pending on the same edge: set wins.
  - CTRL write and one-shot self-clear of en on the same edge: the written value wins.
  - Multiple channels firing on the same edge are independent; irq_id selects the lowest index.
- Masking: im=0 masks the channel from irq, irq_vec and irq_id, but pending still sets and stays readable in STATUS.
- irq, irq_vec and irq_id are combinational from registered state only; there is no path from addr/we/wdata to them.

Decomposition:
- Package irq_timer_pkg:
  - State enum (IDLE, LOAD, CNT, FIRE).
  - Offset constants (OFF_CTRL=0, OFF_PRESET=1, OFF_COUNT=2, OFF_STATUS=3).
  - Mode codes (MODE_ONESHOT=2'b00, MODE_PERIODIC=2'b01).
  - CTRL bit positions.
- Sub-module irq_timer_channel:
  - Holds one channel's registers and FSM; ports: write-enable per offset, wdata, and COUNT/CTRL/PRESET/pending outputs.
  - The top level generates NUM_CH instances, the address decode, the read mux and the priority encoder.

Test Plan:
- Reset: hold reset=0, toggle clk -> every rdata location reads 0 and irq=0. Assert reset low mid-count -> COUNT=0 and irq=0 without a clock edge.
- One-shot: ch0 PRESET=5, CTRL=0b1001 written at edge 0 -> COUNT=5 after edge 2; irq rises after edge 8; CTRL reads 0b1000 (en cleared); COUNT stays 0; no second interrupt.
- Periodic and W1C: ch1 PRESET=3, CTRL=0b1011 -> pending sets every 5 cycles. Write STATUS=1 on the same edge as a FIRE -> pending stays 1. Write on a non-FIRE edge -> pending clears and irq drops.
- Masking and priority (NUM_CH=4): fire ch2 and ch3 on the same edge -> irq_vec=0b1100, irq_id=2. Set ch2 im=0 -> irq_vec=0b1000, irq_id=3, and STATUS of ch2 still reads 1.
- Pause and reprogram: clear en while COUNT=4 -> COUNT holds at 4 for 10 cycles. Write PRESET=7, then set en -> reload to 7 (not resume from 4); interrupt arrives 9 cycles after the LOAD edge.
- Address edge cases: access channel index >= NUM_CH, and write COUNT -> reads return 0, no state changes, irq unaffected.
